pe_feeder: RTL and testbench
============================

PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 Parameters (name, default, meaning): DATA_W, 512, neuron/weight subvector width (32 x 16-bit lanes).
REQ-002 NADDR_W, 10, neuron-buffer address width; WADDR_W, 12, weight-buffer address width.
REQ-003 LEN_W, 6, subvectors-per-vector count width; NOUT_W, 8, output-neuron count width.
REQ-004 Ports (name direction width meaning): clk in 1 clock; rst_n in 1 reset, asynchronous, active-low.
REQ-005 cmd_valid in 1 command offered; cmd_ready out 1 command accepted when both high at a rising edge.
REQ-006 cmd_nbase in NADDR_W neuron base address; cmd_wbase in WADDR_W weight base address.
REQ-007 cmd_len in LEN_W subvectors per vector; cmd_nout in NOUT_W number of output neurons (vectors).
REQ-008 abort in 1 synchronous job cancel.
REQ-009 nbuf_rd_en out 1, nbuf_addr out NADDR_W, nbuf_rdata in DATA_W: neuron buffer, read data valid 1 cycle after rd_en.
REQ-010 wbuf_rd_en out 1, wbuf_addr out WADDR_W, wbuf_rdata in DATA_W: weight buffer, same 1-cycle latency.
REQ-011 neuron out DATA_W, weight out DATA_W, ctrl out 2, vld_o out 1: beat stream to parallel inner-product PE.
REQ-012 busy out 1 job in progress; done out 1 one-cycle job-complete pulse.

Function
REQ-013 FSM states IDLE, RUN, DRAIN; cmd_ready SHALL equal (state==IDLE); busy SHALL equal (state!=IDLE).
REQ-014 IDLE + cmd accepted with cmd_len!=0 and cmd_nout!=0 -> RUN; command fields latched at acceptance.
REQ-015 IDLE + cmd accepted with cmd_len==0 or cmd_nout==0 -> stay IDLE, done pulses next cycle, no reads, no beats.
REQ-016 RUN: exactly one read per cycle on both buffers (nbuf_rd_en=wbuf_rd_en=1), beats ordered j=0..nout-1 outer, i=0..len-1 inner.
REQ-017 Beat (j,i): nbuf_addr = nbase+i; wbuf_addr = wbase + j*len + i; both mod 2^width (wrap-around, no error).
REQ-018 Weight address SHALL be a running pointer incremented by 1 per beat (no multiplier).
REQ-019 First read issued the cycle after command acceptance; reads continuous with no bubbles for len*nout cycles.
REQ-020 RUN -> DRAIN the cycle after the final read issues; DRAIN -> IDLE after one cycle.
REQ-021 vld_o SHALL assert exactly 1 cycle after each read; neuron=nbuf_rdata, weight=wbuf_rdata during vld_o.
REQ-022 ctrl[0]=1 on beat with i==0; ctrl[1]=1 on beat with i==len-1; len==1 -> ctrl=2'b11 every beat.
REQ-023 ctrl SHALL be 2'b00 whenever vld_o=0.
REQ-024 done SHALL pulse 1 cycle coincident with the final beat's vld_o (in DRAIN); next command acceptable the following cycle.
REQ-025 abort in RUN or DRAIN: next cycle state=IDLE, rd_en low, vld_o/ctrl/done low; any read issued in the abort cycle produces no beat.
REQ-026 abort in IDLE ignored; abort and cmd_valid in the same IDLE cycle -> command accepted.
REQ-027 cmd_valid while busy: not accepted, no effect on current job.

Reset
REQ-028 rst_n low: state=IDLE; vld_o=0, ctrl=00, done=0, busy=0, nbuf_rd_en=wbuf_rd_en=0, addresses=0; cmd_ready=1 after release.
REQ-029 Reset mid-job SHALL discard the job with no done pulse; neuron/weight data outputs need no reset.

Structure
REQ-030 Shared NPU package holds DATA_W, lane count (32), lane width (16), NADDR_W, WADDR_W, LEN_W, NOUT_W, ctrl bit positions (FIRST=0, LAST=1).
REQ-031 Single module, no sub-modules; i/j counters, address pointers, 1-stage vld/ctrl pipeline register.

Verification
REQ-032 nbase=0x010, wbase=0x100, len=4, nout=2 -> 8 beats, n-addr 10,11,12,13,10,11,12,13, w-addr 100..107, ctrl 01,00,00,10 per vector, done on beat 8.
REQ-033 len=1, nout=3 -> 3 consecutive beats, ctrl=11 each, done with beat 3, busy high 4 cycles.
REQ-034 nbase=0x3FE, wbase=0xFFE, len=3, nout=1 -> n-addr 3FE,3FF,000; w-addr FFE,FFF,000.
REQ-035 len=0, nout=5 -> no rd_en, no vld_o, done 1 cycle after acceptance.
REQ-036 len=4, nout=4, abort after 6th read -> 5 beats emitted, then idle, no done; new command accepted next cycle runs normally.
REQ-037 rst_n low during beat 3 of len=4,nout=2 -> all outputs reset immediately, no done; fresh command after release produces full 8-beat sequence.

Source files
------------

// File: rtl/pe_feeder_pkg.sv
// Shared NPU definitions for the PE feeder: data/lane geometry, buffer
// address widths, job counter widths, beat control bit positions and the
// feeder FSM state type.
package pe_feeder_pkg;

  localparam int LANES   = 32;
  localparam int LANE_W  = 16;
  localparam int DATA_W  = LANES * LANE_W;
  localparam int NADDR_W = 10;
  localparam int WADDR_W = 12;
  localparam int LEN_W   = 6;
  localparam int NOUT_W  = 8;

  // Bit positions inside the 2-bit beat control field
  localparam int CTRL_FIRST = 0;
  localparam int CTRL_LAST  = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fsm_state_t;

  // Build the beat control field from first/last-of-vector flags
  function automatic logic [1:0] ctrl_encode(input logic first, input logic last);
    logic [1:0] c;
    c             = 2'b00;
    c[CTRL_FIRST] = first;
    c[CTRL_LAST]  = last;
    return c;
  endfunction

endpackage

// File: rtl/pe_feeder_if.sv
// Command channel into the PE feeder: a valid/ready handshake carrying the
// neuron base, weight base, subvectors per vector and output neuron count.
interface pe_feeder_if;
  import pe_feeder_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic [NADDR_W-1:0] cmd_nbase;
  logic [WADDR_W-1:0] cmd_wbase;
  logic [LEN_W-1:0]   cmd_len;
  logic [NOUT_W-1:0]  cmd_nout;

  // Command issuer side
  modport master (
    output cmd_valid, cmd_nbase, cmd_wbase, cmd_len, cmd_nout,
    input  cmd_ready
  );

  // Feeder side
  modport slave (
    input  cmd_valid, cmd_nbase, cmd_wbase, cmd_len, cmd_nout,
    output cmd_ready
  );

endinterface

// File: rtl/pe_feeder.sv
// PE feeder: walks a neuron buffer and a weight buffer for one job and
// streams (neuron, weight) subvector pairs to the inner-product PE.
// For output neuron j and subvector i the neuron read is nbase+i and the
// weight read is a running pointer starting at wbase, so no multiplier is
// needed. One read per cycle on both buffers; the 1-cycle buffer latency
// is matched by a single vld/ctrl pipeline stage.
module pe_feeder #(
  parameter int DATA_W  = pe_feeder_pkg::DATA_W,
  parameter int NADDR_W = pe_feeder_pkg::NADDR_W,
  parameter int WADDR_W = pe_feeder_pkg::WADDR_W,
  parameter int LEN_W   = pe_feeder_pkg::LEN_W,
  parameter int NOUT_W  = pe_feeder_pkg::NOUT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  pe_feeder_if.slave         cmd,
  input  logic               abort,
  output logic               nbuf_rd_en,
  output logic [NADDR_W-1:0] nbuf_addr,
  input  logic [DATA_W-1:0]  nbuf_rdata,
  output logic               wbuf_rd_en,
  output logic [WADDR_W-1:0] wbuf_addr,
  input  logic [DATA_W-1:0]  wbuf_rdata,
  output logic [DATA_W-1:0]  neuron,
  output logic [DATA_W-1:0]  weight,
  output logic [1:0]         ctrl,
  output logic               vld_o,
  output logic               busy,
  output logic               done
);
  import pe_feeder_pkg::*;

  fsm_state_t         r_state;
  logic [NADDR_W-1:0] r_nbase;
  logic [NADDR_W-1:0] r_naddr;
  logic [WADDR_W-1:0] r_waddr;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_i;
  logic [NOUT_W-1:0]  r_nout;
  logic [NOUT_W-1:0]  r_j;
  logic               r_rd_en;
  logic               r_vld;
  logic [1:0]         r_ctrl;
  logic               r_done;

  logic w_accept;
  logic w_cmd_empty;
  logic w_first_i;
  logic w_last_i;
  logic w_last_j;

  // Handshake decode and position-in-job flags for the read being issued
  always_comb begin
    w_accept    = cmd.cmd_valid && (r_state == ST_IDLE);
    w_cmd_empty = (cmd.cmd_len == {LEN_W{1'b0}}) || (cmd.cmd_nout == {NOUT_W{1'b0}});
    w_first_i   = (r_i == {LEN_W{1'b0}});
    w_last_i    = (r_i == (r_len - LEN_W'(1)));
    w_last_j    = (r_j == (r_nout - NOUT_W'(1)));
  end

  // Job FSM: counters, address pointers, read strobe and beat pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_nbase <= {NADDR_W{1'b0}};
      r_naddr <= {NADDR_W{1'b0}};
      r_waddr <= {WADDR_W{1'b0}};
      r_len   <= {LEN_W{1'b0}};
      r_i     <= {LEN_W{1'b0}};
      r_nout  <= {NOUT_W{1'b0}};
      r_j     <= {NOUT_W{1'b0}};
      r_rd_en <= 1'b0;
      r_vld   <= 1'b0;
      r_ctrl  <= 2'b00;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // abort is meaningless here; a command offered with it is still taken
          r_vld   <= 1'b0;
          r_ctrl  <= 2'b00;
          r_rd_en <= 1'b0;
          r_done  <= 1'b0;
          if (w_accept) begin
            if (w_cmd_empty) begin
              // empty job completes immediately without touching the buffers
              r_done <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_rd_en <= 1'b1;
              r_nbase <= cmd.cmd_nbase;
              r_len   <= cmd.cmd_len;
              r_nout  <= cmd.cmd_nout;
              r_naddr <= cmd.cmd_nbase;
              r_waddr <= cmd.cmd_wbase;
              r_i     <= {LEN_W{1'b0}};
              r_j     <= {NOUT_W{1'b0}};
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            // the read issued this cycle is dropped: no beat follows it
            r_state <= ST_IDLE;
            r_rd_en <= 1'b0;
            r_vld   <= 1'b0;
            r_ctrl  <= 2'b00;
            r_done  <= 1'b0;
          end else begin
            r_vld   <= 1'b1;
            r_ctrl  <= ctrl_encode(w_first_i, w_last_i);
            r_waddr <= r_waddr + WADDR_W'(1);
            r_done  <= w_last_i && w_last_j;
            if (w_last_i) begin
              r_i     <= {LEN_W{1'b0}};
              r_naddr <= r_nbase;
              r_j     <= r_j + NOUT_W'(1);
              if (w_last_j) begin
                r_state <= ST_DRAIN;
                r_rd_en <= 1'b0;
              end else begin
                r_rd_en <= 1'b1;
              end
            end else begin
              r_i     <= r_i + LEN_W'(1);
              r_naddr <= r_naddr + NADDR_W'(1);
              r_rd_en <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          // final beat and done are visible this cycle; abort changes nothing
          r_state <= ST_IDLE;
          r_rd_en <= 1'b0;
          r_vld   <= 1'b0;
          r_ctrl  <= 2'b00;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_rd_en <= 1'b0;
          r_vld   <= 1'b0;
          r_ctrl  <= 2'b00;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd.cmd_ready = (r_state == ST_IDLE);
  assign busy          = (r_state != ST_IDLE);
  assign nbuf_rd_en    = r_rd_en;
  assign wbuf_rd_en    = r_rd_en;
  assign nbuf_addr     = r_naddr;
  assign wbuf_addr     = r_waddr;
  assign vld_o         = r_vld;
  assign ctrl          = r_ctrl;
  assign done          = r_done;
  // buffer read data arrives aligned with vld_o, so it is forwarded directly
  assign neuron        = nbuf_rdata;
  assign weight        = wbuf_rdata;

endmodule

// File: tb/tb_pe_feeder.sv
// Self-checking bench for pe_feeder: a scoreboard of expected reads and
// beats is filled when a command is issued and drained by a negedge monitor.
module tb_pe_feeder;
  import pe_feeder_pkg::*;

  typedef struct {
    logic [NADDR_W-1:0] na;
    logic [WADDR_W-1:0] wa;
    logic [1:0]         ctl;
    logic               last;
  } exp_t;

  logic               clk;
  logic               rst_n;
  logic               abort;
  logic               nbuf_rd_en;
  logic [NADDR_W-1:0] nbuf_addr;
  logic [DATA_W-1:0]  nbuf_rdata;
  logic               wbuf_rd_en;
  logic [WADDR_W-1:0] wbuf_addr;
  logic [DATA_W-1:0]  wbuf_rdata;
  logic [DATA_W-1:0]  neuron;
  logic [DATA_W-1:0]  weight;
  logic [1:0]         ctrl;
  logic               vld_o;
  logic               busy;
  logic               done;

  int checks     = 0;
  int failures   = 0;
  int done_cnt   = 0;
  int done_novld = 0;
  int busy_cyc   = 0;
  exp_t rd_q[$];
  exp_t bt_q[$];
  exp_t mon_e;

  pe_feeder_if u_if();

  pe_feeder u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (u_if),
    .abort      (abort),
    .nbuf_rd_en (nbuf_rd_en),
    .nbuf_addr  (nbuf_addr),
    .nbuf_rdata (nbuf_rdata),
    .wbuf_rd_en (wbuf_rd_en),
    .wbuf_addr  (wbuf_addr),
    .wbuf_rdata (wbuf_rdata),
    .neuron     (neuron),
    .weight     (weight),
    .ctrl       (ctrl),
    .vld_o      (vld_o),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] nmem(input logic [NADDR_W-1:0] a);
    return {16{22'h2A5A5A, a}};
  endfunction

  function automatic logic [DATA_W-1:0] wmem(input logic [WADDR_W-1:0] a);
    return {16{20'hC3C3C, a}};
  endfunction

  task automatic chk_eq(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // Buffer models with one cycle of read latency
  always @(posedge clk) begin
    if (nbuf_rd_en) nbuf_rdata <= nmem(nbuf_addr);
    if (wbuf_rd_en) wbuf_rdata <= wmem(wbuf_addr);
  end

  // Monitor: compare reads and beats against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      if (done && !vld_o) done_novld++;
      chk_eq("ready_vs_busy", u_if.cmd_ready, !busy);
      if (nbuf_rd_en || wbuf_rd_en) begin
        if (rd_q.size() == 0) begin
          chk_eq("rd_unexpected", 1'b1, 1'b0);
        end else begin
          mon_e = rd_q.pop_front();
          chk_eq("n_rd_en", nbuf_rd_en, 1'b1);
          chk_eq("w_rd_en", wbuf_rd_en, 1'b1);
          chk_eq("n_addr", nbuf_addr, mon_e.na);
          chk_eq("w_addr", wbuf_addr, mon_e.wa);
        end
      end
      if (vld_o) begin
        if (bt_q.size() == 0) begin
          chk_eq("beat_unexpected", 1'b1, 1'b0);
        end else begin
          mon_e = bt_q.pop_front();
          chk_eq("neuron", neuron, nmem(mon_e.na));
          chk_eq("weight", weight, wmem(mon_e.wa));
          chk_eq("ctrl", ctrl, mon_e.ctl);
          chk_eq("done_on_beat", done, mon_e.last);
        end
      end else begin
        chk_eq("ctrl_idle", ctrl, 2'b00);
      end
    end
  end

  task automatic push_exp(input logic [NADDR_W-1:0] nb, input logic [WADDR_W-1:0] wb,
                          input int len, input int nout, input int abort_at);
    int total;
    int nreads;
    int nbeats;
    exp_t e;
    total  = len * nout;
    nreads = (abort_at > 0) ? abort_at : total;
    nbeats = (abort_at > 0) ? abort_at - 1 : total;
    for (int k = 0; k < nreads; k++) begin
      e.na   = nb + NADDR_W'(k % len);
      e.wa   = wb + WADDR_W'(k);
      e.ctl  = 2'b00;
      e.ctl[CTRL_FIRST] = ((k % len) == 0);
      e.ctl[CTRL_LAST]  = ((k % len) == len - 1);
      e.last = (k == total - 1) && (abort_at == 0);
      rd_q.push_back(e);
      if (k < nbeats) bt_q.push_back(e);
    end
  endtask

  task automatic issue_cmd(input logic [NADDR_W-1:0] nb, input logic [WADDR_W-1:0] wb,
                           input int len, input int nout, input bit with_abort);
    @(posedge clk);
    #1;
    u_if.cmd_valid = 1'b1;
    u_if.cmd_nbase = nb;
    u_if.cmd_wbase = wb;
    u_if.cmd_len   = LEN_W'(len);
    u_if.cmd_nout  = NOUT_W'(nout);
    abort          = with_abort;
    chk_eq("cmd_ready", u_if.cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    u_if.cmd_valid = 1'b0;
    abort          = 1'b0;
  endtask

  task automatic run_job(input logic [NADDR_W-1:0] nb, input logic [WADDR_W-1:0] wb,
                         input int len, input int nout, input int abort_at,
                         input bit abort_with_cmd, input bit junk_cmd);
    int total;
    bit timed_out;
    total      = len * nout;
    done_cnt   = 0;
    done_novld = 0;
    busy_cyc   = 0;
    push_exp(nb, wb, len, nout, abort_at);
    issue_cmd(nb, wb, len, nout, abort_with_cmd);
    if (total == 0) begin
      chk_eq("done_empty", done, 1'b1);
      chk_eq("busy_empty", busy, 1'b0);
    end
    if (junk_cmd) begin
      u_if.cmd_valid = 1'b1;
      u_if.cmd_nbase = 10'h3AA;
      u_if.cmd_wbase = 12'h555;
      u_if.cmd_len   = 6'd1;
      u_if.cmd_nout  = 8'd1;
      @(posedge clk);
      #1;
      u_if.cmd_valid = 1'b0;
    end
    if (abort_at > 0) begin
      repeat (abort_at - 1) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      chk_eq("idle_after_abort", busy, 1'b0);
      chk_eq("ready_after_abort", u_if.cmd_ready, 1'b1);
    end
    timed_out = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (!busy && rd_q.size() == 0 && bt_q.size() == 0) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_eq("timeout", timed_out, 1'b0);
    chk_eq("reads_left", rd_q.size(), 0);
    chk_eq("beats_left", bt_q.size(), 0);
    chk_eq("done_count", done_cnt, (abort_at > 0) ? 0 : 1);
    chk_eq("done_no_beat", done_novld, (total == 0) ? 1 : 0);
    chk_eq("busy_cycles", busy_cyc, (total == 0) ? 0 : ((abort_at > 0) ? abort_at : total + 1));
    rd_q.delete();
    bt_q.delete();
  endtask

  initial begin
    rst_n          = 1'b0;
    abort          = 1'b0;
    u_if.cmd_valid = 1'b0;
    u_if.cmd_nbase = '0;
    u_if.cmd_wbase = '0;
    u_if.cmd_len   = '0;
    u_if.cmd_nout  = '0;
    #3;
    chk_eq("rst_vld", vld_o, 1'b0);
    chk_eq("rst_ctrl", ctrl, 2'b00);
    chk_eq("rst_done", done, 1'b0);
    chk_eq("rst_busy", busy, 1'b0);
    chk_eq("rst_rd_en", {nbuf_rd_en, wbuf_rd_en}, 2'b00);
    chk_eq("rst_naddr", nbuf_addr, 10'h000);
    chk_eq("rst_waddr", wbuf_addr, 12'h000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_eq("ready_after_rst", u_if.cmd_ready, 1'b1);

    // two vectors of four subvectors; a command offered mid-job is ignored
    run_job(10'h010, 12'h100, 4, 2, 0, 1'b0, 1'b1);
    // single-subvector vectors
    run_job(10'h020, 12'h200, 1, 3, 0, 1'b0, 1'b0);
    // address wrap on both buffers, abort offered with the command in idle
    run_job(10'h3FE, 12'hFFE, 3, 1, 0, 1'b1, 1'b0);
    // empty jobs
    run_job(10'h000, 12'h000, 0, 5, 0, 1'b0, 1'b0);
    run_job(10'h005, 12'h050, 3, 0, 0, 1'b0, 1'b0);
    // abort during the sixth read, then a normal job
    run_job(10'h040, 12'h400, 4, 4, 6, 1'b0, 1'b0);
    run_job(10'h100, 12'h800, 2, 3, 0, 1'b0, 1'b0);

    // reset during the third beat discards the job
    done_cnt = 0;
    push_exp(10'h010, 12'h100, 4, 2, 0);
    issue_cmd(10'h010, 12'h100, 4, 2, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_eq("midrst_vld", vld_o, 1'b0);
    chk_eq("midrst_ctrl", ctrl, 2'b00);
    chk_eq("midrst_done", done, 1'b0);
    chk_eq("midrst_busy", busy, 1'b0);
    chk_eq("midrst_rd_en", {nbuf_rd_en, wbuf_rd_en}, 2'b00);
    chk_eq("midrst_addr", {nbuf_addr, wbuf_addr}, 22'h0);
    chk_eq("midrst_done_cnt", done_cnt, 0);
    chk_eq("midrst_reads_seen", rd_q.size(), 5);
    chk_eq("midrst_beats_seen", bt_q.size(), 6);
    rd_q.delete();
    bt_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_eq("ready_after_midrst", u_if.cmd_ready, 1'b1);
    run_job(10'h010, 12'h100, 4, 2, 0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
